// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus tick-sampled stability filter per switch bit.
// Define SW_DEBOUNCE_BYPASS_EN to drop the filter and pass the synchronised bus straight through.
module sw_debounce #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 100000,
    parameter int SAMPLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_chg,
    output logic             tick
);
    logic [WIDTH-1:0] sync1_q, sync2_q, sw_db_q, sw_db_d;
    logic             sw_chg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sw_db_q  <= '0;
            sw_chg_q <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            sw_db_q  <= sw_db_d;
            sw_chg_q <= |(sw_db_d ^ sw_db_q);
        end
    end

`ifdef SW_DEBOUNCE_BYPASS_EN
    assign sw_db_d = sync2_q;
    assign tick    = 1'b0;
`else
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           tick_q, tick_d;
    logic [WIDTH-1:0][SAMPLES-1:0]  hist_q, hist_d;

    // History shifts only while tick_q is high; acceptance looks at the freshly shifted history.
    always_comb begin
        tick_d  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d   = tick_d ? '0 : cnt_q + 1'b1;
        hist_d  = hist_q;
        sw_db_d = sw_db_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick_q) begin
                hist_d[i]  = {hist_q[i][SAMPLES-2:0], sync2_q[i]};
                sw_db_d[i] = (&hist_d[i]) ? 1'b1 : (~|hist_d[i]) ? 1'b0 : sw_db_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            hist_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            hist_q <= hist_d;
        end
    end

    assign tick = tick_q;
`endif

    assign sw_db  = sw_db_q;
    assign sw_chg = sw_chg_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized and directed checks of sw_debounce against a run-length reference model.
module tb_sw_debounce;
    localparam int W  = 16;
    localparam int TD = 4;
    localparam int S  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db;
    logic         sw_chg, tick;

    int checks = 0;
    int errors = 0;

    // Reference: a bit is accepted once S consecutive tick samples of the 2-edge-delayed input agree.
    logic [W-1:0] m_s1, m_s2, m_db, runv;
    logic         m_chg, m_tick;
    int           m_e;
    int           run [W];

    sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .SAMPLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_db(sw_db), .sw_chg(sw_chg), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; runv = '0;
        m_chg = 1'b0; m_tick = 1'b0; m_e = 0;
        for (int i = 0; i < W; i++) run[i] = S;
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] nd;
        nd = m_db;
`ifdef SW_DEBOUNCE_BYPASS_EN
        nd = m_s2;
`else
        if (m_tick) begin
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == runv[i]) begin
                    if (run[i] < S) run[i]++;
                end else begin
                    runv[i] = m_s2[i];
                    run[i]  = 1;
                end
                if (run[i] >= S) nd[i] = runv[i];
            end
        end
`endif
        m_chg = (nd != m_db);
        m_db  = nd;
        m_s2  = m_s1;
        m_s1  = raw;
        m_e++;
`ifdef SW_DEBOUNCE_BYPASS_EN
        m_tick = 1'b0;
`else
        m_tick = (m_e % TD == 0);
`endif
    endtask

    task automatic cycle(input logic [W-1:0] raw);
        sw_raw = raw;
        @(posedge clk);
        if (rst_n) model_edge(raw);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            cycle(16'hFFFF);
            checks++;
            if (sw_db !== 16'h0000 || sw_chg !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: db=%h chg=%b tick=%b, want db=0000 chg=0 tick=0", sw_db, sw_chg, tick);
            end
        end
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle(16'h0000);
            if (tick === 1'b1 && first < 0) first = k;
            checks++;
            if (sw_db !== m_db || sw_chg !== m_chg || tick !== m_tick) begin
                errors++;
                $display("FAIL reset_release: db=%h chg=%b tick=%b, want db=%h chg=%b tick=%b",
                         sw_db, sw_chg, tick, m_db, m_chg, m_tick);
            end
        end
`ifndef SW_DEBOUNCE_BYPASS_EN
        checks++;
        if (first != TD) begin
            errors++;
            $display("FAIL first_tick: cycle %0d, want %0d", first, TD);
        end
`endif
    endtask

    task automatic test_clean_step();
        int first, pulses, idle;
        idle = int'($urandom_range(0, 7));
        for (int k = 0; k < idle; k++) cycle(16'h0000);
        first = -1;
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            cycle(16'h000B);
            if (sw_db === 16'h000B && first < 0) first = k;
            if (sw_chg === 1'b1) begin
                pulses++;
                checks++;
                if (k != first) begin
                    errors++;
                    $display("FAIL step_chg_align: pulse at %0d, want %0d", k, first);
                end
            end
            checks++;
            if (sw_db !== m_db || sw_chg !== m_chg || tick !== m_tick) begin
                errors++;
                $display("FAIL step_model: db=%h chg=%b tick=%b, want db=%h chg=%b tick=%b",
                         sw_db, sw_chg, tick, m_db, m_chg, m_tick);
            end
        end
        checks++;
        if (first < 2 + (S - 1) * TD + 1 || first > 2 + S * TD) begin
            errors++;
            $display("FAIL step_latency: %0d cycles, want %0d..%0d", first, 2 + (S - 1) * TD + 1, 2 + S * TD);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL step_pulses: %0d, want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        logic [W-1:0] v;
        for (int k = 0; k < 25; k++) cycle(16'h0000);
        checks++;
        if (sw_db !== 16'h0000) begin
            errors++;
            $display("FAIL bounce_pre: db=%h, want 0000", sw_db);
        end
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            v = (k < 40 && ((k / TD) % 2 == 0)) ? 16'h0001 : 16'h0000;
            cycle(v);
            if (sw_chg === 1'b1) pulses++;
            checks++;
            if (sw_db !== 16'h0000 || sw_db !== m_db || sw_chg !== m_chg) begin
                errors++;
                $display("FAIL bounce_db: db=%h chg=%b, want db=0000 (model %h) chg=%b", sw_db, sw_chg, m_db, m_chg);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_pulses: %0d, want 0", pulses);
        end
    endtask

    task automatic test_multibit();
        int pulses;
        for (int k = 0; k < 25; k++) cycle(16'h40F0);
        checks++;
        if (sw_db !== 16'h40F0) begin
            errors++;
            $display("FAIL multi_settle: db=%h, want 40F0", sw_db);
        end
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            cycle(16'h8EAA);
            if (sw_chg === 1'b1) pulses++;
            checks++;
            if ((sw_db !== 16'h40F0 && sw_db !== 16'h8EAA) || sw_db !== m_db || sw_chg !== m_chg) begin
                errors++;
                $display("FAIL multi_path: db=%h chg=%b, want db=%h chg=%b", sw_db, sw_chg, m_db, m_chg);
            end
        end
        checks++;
        if (sw_db !== 16'h8EAA || pulses != 1) begin
            errors++;
            $display("FAIL multi_final: db=%h pulses=%0d, want db=8EAA pulses=1", sw_db, pulses);
        end
    endtask

    task automatic test_reset_mid();
        int ticks, first;
        for (int k = 0; k < 25; k++) cycle(16'h00FF);
        ticks = 0;
        for (int k = 0; k < 20 && ticks < 3; k++) begin
            cycle(16'hFFFF);
            if (m_tick) ticks++;
            checks++;
            if (sw_db !== m_db || sw_chg !== m_chg || tick !== m_tick) begin
                errors++;
                $display("FAIL mid_pre: db=%h chg=%b tick=%b, want db=%h chg=%b tick=%b",
                         sw_db, sw_chg, tick, m_db, m_chg, m_tick);
            end
        end
        checks++;
        if (sw_db !== 16'h00FF) begin
            errors++;
            $display("FAIL mid_partial: db=%h, want 00FF", sw_db);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sw_db !== 16'h0000 || sw_chg !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clear: db=%h chg=%b tick=%b, want 0000/0/0", sw_db, sw_chg, tick);
        end
        model_reset();
        @(negedge clk);
        cycle(16'hFFFF);
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 24; k++) begin
            cycle(16'hFFFF);
            if (sw_db === 16'hFFFF && first < 0) first = k;
            checks++;
            if (sw_db !== m_db || sw_chg !== m_chg || tick !== m_tick) begin
                errors++;
                $display("FAIL mid_post: db=%h chg=%b tick=%b, want db=%h chg=%b tick=%b",
                         sw_db, sw_chg, tick, m_db, m_chg, m_tick);
            end
        end
        checks++;
        if (first != S * TD + 1) begin
            errors++;
            $display("FAIL mid_relatch: cycle %0d, want %0d", first, S * TD + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v, mask;
        int hold;
        for (int n = 0; n < 60; n++) begin
            v    = W'($urandom);
            hold = int'($urandom_range(1, 24));
            mask = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            for (int k = 0; k < hold; k++) begin
                cycle(v ^ (mask & W'($urandom)));
                checks++;
                if (sw_db !== m_db || sw_chg !== m_chg || tick !== m_tick) begin
                    errors++;
                    $display("FAIL random: db=%h chg=%b tick=%b, want db=%h chg=%b tick=%b",
                             sw_db, sw_chg, tick, m_db, m_chg, m_tick);
                end
            end
        end
    endtask

`ifdef SW_DEBOUNCE_BYPASS_EN
    task automatic test_bypass();
        int first, pulses;
        for (int k = 0; k < 5; k++) cycle(16'h0000);
        first = -1;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(16'hCFFF);
            if (sw_db === 16'hCFFF && first < 0) first = k;
            if (sw_chg === 1'b1) pulses++;
            checks++;
            if (tick !== 1'b0 || sw_db !== m_db || sw_chg !== m_chg) begin
                errors++;
                $display("FAIL bypass_model: db=%h chg=%b tick=%b, want db=%h chg=%b tick=0",
                         sw_db, sw_chg, tick, m_db, m_chg);
            end
        end
        checks++;
        if (first != 3 || pulses != 1) begin
            errors++;
            $display("FAIL bypass_latency: cycle %0d pulses %0d, want 3 and 1", first, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SW_DEBOUNCE_BYPASS_EN
        test_bypass();
`else
        test_clean_step();
        test_bounce();
        test_multibit();
        test_reset_mid();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
